// File: rtl/usb_slave_fifo.sv
// Chip-side responder for the CY68013 slave-FIFO bus: EP2 is loaded by the host and read by the
// bus master, EP6 is written by the bus master and drained by the host. EP4/EP8 are inert.
module usb_slave_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  fpga_gclk,
  input  logic                  reset,
  input  logic [1:0]            usb_fifoaddr,
  input  logic                  usb_slcs,
  input  logic                  usb_sloe,
  input  logic                  usb_slrd,
  input  logic                  usb_slwr,
  inout  wire  [15:0]           usb_fd,
  output logic                  usb_flaga,
  output logic                  usb_flagb,
  output logic                  usb_flagc,
  input  logic                  host_wr_valid,
  input  logic [15:0]           host_wr_data,
  output logic                  host_wr_ready,
  output logic                  host_rd_valid,
  output logic [15:0]           host_rd_data,
  input  logic                  host_rd_ready,
  output logic                  ovf_err,
  output logic                  udf_err,
  output logic [DEPTH_LOG2:0]   ep2_count,
  output logic [DEPTH_LOG2:0]   ep6_count
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] L_FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] L_CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] L_PTR_ONE = DEPTH_LOG2'(1);

  logic                  r_slrd_q, r_slwr_q;
  logic [15:0]           r_ep2_mem [DEPTH];
  logic [15:0]           r_ep6_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_ep2_wptr, r_ep2_rptr, r_ep6_wptr, r_ep6_rptr;
  logic [DEPTH_LOG2:0]   r_ep2_count, r_ep6_count;
  logic [DEPTH_LOG2:0]   w_ep2_count_next, w_ep6_count_next;
  logic                  r_flaga, r_flagc, r_ovf, r_udf;

  logic w_rd_event, w_wr_event, w_ep2_sel, w_ep6_sel;
  logic w_ep2_empty, w_ep2_full, w_ep6_empty, w_ep6_full;
  logic w_ep2_push, w_ep2_pop, w_ep6_push, w_ep6_pop;
  logic w_fd_oe;
  logic [15:0] w_fd_out;

  // An event is the release (0->1) of a strobe; a held-low strobe therefore counts once.
  assign w_rd_event = ~usb_slcs & ~r_slrd_q & usb_slrd;
  assign w_wr_event = ~usb_slcs & ~r_slwr_q & usb_slwr;
  assign w_ep2_sel  = (usb_fifoaddr == 2'b00);
  assign w_ep6_sel  = (usb_fifoaddr == 2'b10);

  assign w_ep2_empty = (r_ep2_count == '0);
  assign w_ep2_full  = (r_ep2_count == L_FULL);
  assign w_ep6_empty = (r_ep6_count == '0);
  assign w_ep6_full  = (r_ep6_count == L_FULL);

  // Full/empty use the start-of-cycle count, so a same-cycle drain never rescues a write to full EP6.
  assign w_ep2_push = host_wr_valid & ~w_ep2_full;
  assign w_ep2_pop  = w_rd_event & w_ep2_sel & ~w_ep2_empty;
  assign w_ep6_push = w_wr_event & w_ep6_sel & ~w_ep6_full;
  assign w_ep6_pop  = host_rd_ready & ~w_ep6_empty;

  assign w_fd_oe  = ~reset & ~usb_slcs & ~usb_sloe;
  assign w_fd_out = w_ep2_sel ? r_ep2_mem[r_ep2_rptr] : 16'h0000;
  assign usb_fd   = w_fd_oe ? w_fd_out : 16'hzzzz;

  always_comb begin
    w_ep2_count_next = r_ep2_count;
    w_ep6_count_next = r_ep6_count;
    if (w_ep2_push && !w_ep2_pop) w_ep2_count_next = r_ep2_count + L_CNT_ONE;
    else if (w_ep2_pop && !w_ep2_push) w_ep2_count_next = r_ep2_count - L_CNT_ONE;
    if (w_ep6_push && !w_ep6_pop) w_ep6_count_next = r_ep6_count + L_CNT_ONE;
    else if (w_ep6_pop && !w_ep6_push) w_ep6_count_next = r_ep6_count - L_CNT_ONE;
  end

  always_ff @(posedge fpga_gclk) begin
    if (w_ep2_push) r_ep2_mem[r_ep2_wptr] <= host_wr_data;
    if (w_ep6_push) r_ep6_mem[r_ep6_wptr] <= usb_fd;
  end

  always_ff @(posedge fpga_gclk) begin
    if (reset) begin
      r_slrd_q    <= 1'b1;
      r_slwr_q    <= 1'b1;
      r_ep2_wptr  <= '0;
      r_ep2_rptr  <= '0;
      r_ep6_wptr  <= '0;
      r_ep6_rptr  <= '0;
      r_ep2_count <= '0;
      r_ep6_count <= '0;
      r_flaga     <= 1'b0;
      r_flagc     <= 1'b1;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_slrd_q    <= usb_slrd;
      r_slwr_q    <= usb_slwr;
      if (w_ep2_push) r_ep2_wptr <= r_ep2_wptr + L_PTR_ONE;
      if (w_ep2_pop)  r_ep2_rptr <= r_ep2_rptr + L_PTR_ONE;
      if (w_ep6_push) r_ep6_wptr <= r_ep6_wptr + L_PTR_ONE;
      if (w_ep6_pop)  r_ep6_rptr <= r_ep6_rptr + L_PTR_ONE;
      r_ep2_count <= w_ep2_count_next;
      r_ep6_count <= w_ep6_count_next;
      r_flaga     <= (w_ep2_count_next != '0);
      r_flagc     <= (w_ep6_count_next != L_FULL);
      if (w_rd_event && w_ep2_sel && w_ep2_empty) r_udf <= 1'b1;
      if (w_wr_event && w_ep6_sel && w_ep6_full)  r_ovf <= 1'b1;
    end
  end

  assign usb_flaga     = r_flaga;
  assign usb_flagb     = 1'b0;
  assign usb_flagc     = r_flagc;
  assign host_wr_ready = ~w_ep2_full;
  assign host_rd_valid = ~w_ep6_empty;
  assign host_rd_data  = r_ep6_mem[r_ep6_rptr];
  assign ovf_err       = r_ovf;
  assign udf_err       = r_udf;
  assign ep2_count     = r_ep2_count;
  assign ep6_count     = r_ep6_count;

endmodule

// File: tb/tb_usb_slave_fifo.sv
// Bench for usb_slave_fifo: directed scenarios then random traffic, all checked against
// a queue-based model of the two endpoint FIFOs.
module tb_usb_slave_fifo;

  logic        fpga_gclk = 1'b0;
  logic        rst, cs, oe, rd, wr, hwv, hrr;
  logic [1:0]  addr;
  logic [15:0] drv, hwd;
  wire  [15:0] usb_fd;
  logic        flaga, flagb, flagc, hw_ready, hr_valid, ovf, udf;
  logic [15:0] hr_data;
  logic [4:0]  ep2_cnt, ep6_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_ep2[$];
  logic [15:0] m_ep6[$];
  logic        m_ovf, m_udf, m_prd, m_pwr;

  always #5 fpga_gclk = ~fpga_gclk;

  // The master drives the bus whenever it is not asking the chip to drive.
  assign usb_fd = oe ? drv : 16'hzzzz;

  usb_slave_fifo #(.DEPTH_LOG2(4)) dut (
    .fpga_gclk(fpga_gclk), .reset(rst), .usb_fifoaddr(addr), .usb_slcs(cs),
    .usb_sloe(oe), .usb_slrd(rd), .usb_slwr(wr), .usb_fd(usb_fd),
    .usb_flaga(flaga), .usb_flagb(flagb), .usb_flagc(flagc),
    .host_wr_valid(hwv), .host_wr_data(hwd), .host_wr_ready(hw_ready),
    .host_rd_valid(hr_valid), .host_rd_data(hr_data), .host_rd_ready(hrr),
    .ovf_err(ovf), .udf_err(udf), .ep2_count(ep2_cnt), .ep6_count(ep6_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the endpoint rules to the inputs presented for the coming edge.
  task automatic model_eval();
    int s2, s6;
    logic rd_ev, wr_ev;
    logic [15:0] fdv;
    if (rst) begin
      m_ep2.delete();
      m_ep6.delete();
      m_ovf = 0; m_udf = 0; m_prd = 1; m_pwr = 1;
    end else begin
      s2 = m_ep2.size();
      s6 = m_ep6.size();
      rd_ev = !cs && !m_prd && rd;
      wr_ev = !cs && !m_pwr && wr;
      fdv = oe ? drv : 16'h0000;
      if (rd_ev && addr == 2'b00) begin
        if (s2 > 0) void'(m_ep2.pop_front());
        else m_udf = 1;
      end
      if (hwv && s2 < 16) m_ep2.push_back(hwd);
      if (wr_ev && addr == 2'b10) begin
        if (s6 < 16) m_ep6.push_back(fdv);
        else m_ovf = 1;
      end
      if (hrr && s6 > 0) void'(m_ep6.pop_front());
      m_prd = rd;
      m_pwr = wr;
    end
  endtask

  task automatic check_outputs();
    check("ep2_count", 32'(ep2_cnt), m_ep2.size());
    check("ep6_count", 32'(ep6_cnt), m_ep6.size());
    check("flaga", 32'(flaga), 32'(m_ep2.size() != 0));
    check("flagb", 32'(flagb), 0);
    check("flagc", 32'(flagc), 32'(m_ep6.size() != 16));
    check("ovf_err", 32'(ovf), 32'(m_ovf));
    check("udf_err", 32'(udf), 32'(m_udf));
    check("host_wr_ready", 32'(hw_ready), 32'(m_ep2.size() < 16));
    check("host_rd_valid", 32'(hr_valid), 32'(m_ep6.size() > 0));
    if (m_ep6.size() > 0) check("host_rd_data", 32'(hr_data), 32'(m_ep6[0]));
    if (!rst && !cs && !oe) begin
      if (addr != 2'b00) check("fd_other_ep", 32'(usb_fd), 0);
      else if (m_ep2.size() > 0) check("fd_ep2_head", 32'(usb_fd), 32'(m_ep2[0]));
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge fpga_gclk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1; cs = 1; oe = 1; rd = 1; wr = 1; hwv = 0; hrr = 0; addr = 2'b00;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    drv = 16'h0000; hwd = 16'h0000;
    do_reset();
    check("reset_flagc", 32'(flagc), 1);
    check("reset_flaga", 32'(flaga), 0);

    // EP2 readout with long read strobes
    hwv = 1; hwd = 16'hA5A5; step();
    hwd = 16'h1234; step();
    hwv = 0; cs = 0; oe = 0; addr = 2'b00; rd = 1; step();
    check("ep2_first_word", 32'(usb_fd), 32'h0000A5A5);
    rd = 0; for (int i = 0; i < 9; i++) step();
    rd = 1; step();
    check("ep2_second_word", 32'(usb_fd), 32'h00001234);
    rd = 0; for (int i = 0; i < 9; i++) step();
    rd = 1; step();
    check("ep2_flaga_clear", 32'(flaga), 0);

    // EP6 single write
    do_reset();
    cs = 0; oe = 1; addr = 2'b10; drv = 16'hBEEF;
    wr = 0; for (int i = 0; i < 9; i++) step();
    wr = 1; step();
    check("ep6_one_count", 32'(ep6_cnt), 1);
    check("ep6_one_data", 32'(hr_data), 32'h0000BEEF);
    check("ep6_one_valid", 32'(hr_valid), 1);

    // EP6 full, then a write that must be dropped despite a same-cycle drain
    do_reset();
    cs = 0; oe = 1; addr = 2'b10;
    for (int i = 0; i < 16; i++) begin
      drv = 16'(16'h0100 + i); wr = 0; step(); wr = 1; step();
    end
    check("ep6_full_flagc", 32'(flagc), 0);
    drv = 16'hDEAD; wr = 0; step();
    hrr = 1; wr = 1; step();
    check("ep6_ovf_set", 32'(ovf), 1);
    check("ep6_after_ovf_count", 32'(ep6_cnt), 15);
    for (int i = 0; i < 16; i++) begin
      if (hr_valid) check("ep6_no_dead", 32'(hr_data != 16'hDEAD), 1);
      step();
    end
    hrr = 0;

    // EP2 underflow leaves pointers alone
    do_reset();
    cs = 0; oe = 0; addr = 2'b00; rd = 0; step(); rd = 1; step();
    check("ep2_udf_set", 32'(udf), 1);
    check("ep2_udf_count", 32'(ep2_cnt), 0);
    hwv = 1; hwd = 16'h5A5A; step(); hwv = 0; step();
    check("ep2_after_udf_head", 32'(usb_fd), 32'h00005A5A);
    rd = 0; step(); rd = 1; step();

    // Pointer wrap: 40 words in and out of EP2
    do_reset();
    cs = 0; oe = 0; addr = 2'b00;
    for (int i = 0; i < 40; i++) begin
      hwv = 1; hwd = 16'(16'h3000 + i); step();
      hwv = 0; rd = 0; step();
      check("wrap_data", 32'(usb_fd), 32'(16'h3000 + i));
      rd = 1; step();
    end
    check("wrap_empty", 32'(ep2_cnt), 0);

    // Reset in the middle of a held write strobe
    do_reset();
    cs = 0; oe = 1; addr = 2'b10;
    for (int i = 0; i < 5; i++) begin
      drv = 16'(16'h0700 + i); wr = 0; step(); wr = 1; step();
    end
    check("mid_pre_count", 32'(ep6_cnt), 5);
    drv = 16'h0777; wr = 0; step();
    rst = 1; step(); step();
    rst = 0; wr = 1; step();
    step();
    check("mid_ep6_count", 32'(ep6_cnt), 0);
    check("mid_ep2_count", 32'(ep2_cnt), 0);
    check("mid_flagc", 32'(flagc), 1);
    check("mid_flaga", 32'(flaga), 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      cs   = ($urandom_range(0, 5) == 0);
      oe   = $urandom_range(0, 1);
      addr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                         : ($urandom_range(0, 1) ? 2'b00 : 2'b10);
      rd   = $urandom_range(0, 1);
      wr   = $urandom_range(0, 1);
      drv  = 16'($urandom);
      hwv  = ($urandom_range(0, 2) != 0);
      hwd  = 16'($urandom);
      hrr  = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_slave_fifo.md
USB_SLAVE_FIFO -- requirements
Module: usb_slave_fifo

Synthesizable responder for the CY68013 slave-FIFO bus: it acts as the chip side of an FPGA master and is used in loopback benches and on-board tests.

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of the entry count of each endpoint FIFO (16 entries).
REQ-002 SHALL have port fpga_gclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port usb_fifoaddr, input, 2 bits: endpoint select (00 = EP2, 01 = EP4, 10 = EP6, 11 = EP8).
REQ-005 SHALL have port usb_slcs, input, 1 bit: chip select, active low.
REQ-006 SHALL have port usb_sloe, input, 1 bit: data output enable, active low.
REQ-007 SHALL have port usb_slrd, input, 1 bit: read strobe, active low.
REQ-008 SHALL have port usb_slwr, input, 1 bit: write strobe, active low.
REQ-009 SHALL have port usb_fd, inout, 16 bits: data bus.
REQ-010 SHALL have port usb_flaga, output, 1 bit: 1 = EP2 not empty.
REQ-011 SHALL have port usb_flagb, output, 1 bit: 1 = EP4 not empty; tied to 0 after reset.
REQ-012 SHALL have port usb_flagc, output, 1 bit: 1 = EP6 not full.
REQ-013 SHALL have ports host_wr_valid (input, 1 bit), host_wr_data (input, 16 bits) and host_wr_ready (output, 1 bit): host-side EP2 load interface.
REQ-014 SHALL have ports host_rd_valid (output, 1 bit), host_rd_data (output, 16 bits) and host_rd_ready (input, 1 bit): host-side EP6 drain interface.
REQ-015 SHALL have ports ovf_err and udf_err, output, 1 bit each: sticky EP6 overflow and EP2 underflow flags.
REQ-016 SHALL have ports ep2_count and ep6_count, output, DEPTH_LOG2+1 bits each: FIFO occupancy.

Function
REQ-017 SHALL implement EP2 and EP6 as circular FIFOs of 2^DEPTH_LOG2 x 16 bits; pointers wrap modulo the depth, and the counts range from 0 to 2^DEPTH_LOG2.
REQ-018 SHALL register usb_slrd and usb_slwr once (slrd_q, slwr_q); a strobe event is the 0->1 transition between slrd_q and usb_slrd (or slwr_q and usb_slwr), sampled with usb_slcs = 0.
REQ-019 SHALL drive usb_fd with the EP2 head word (first-word fall-through) when usb_slcs = 0, usb_sloe = 0 and usb_fifoaddr = 00.
REQ-020 SHALL drive usb_fd with 16'h0000 when usb_slcs = 0, usb_sloe = 0 and usb_fifoaddr is not 00, and SHALL leave usb_fd high-Z in every other case.
REQ-021 SHALL pop EP2 on a read-strobe event with usb_fifoaddr = 00 when ep2_count > 0; with ep2_count = 0 it SHALL leave the FIFO unchanged and set udf_err.
REQ-022 SHALL push the usb_fd value sampled in the event cycle into EP6 on a write-strobe event with usb_fifoaddr = 10 when ep6_count < depth; with EP6 full it SHALL drop the word and set ovf_err.
REQ-023 SHALL ignore strobe events addressed to EP4 or EP8 (no state change, no error).
REQ-024 SHALL compute host_wr_ready as (ep2_count < depth) and push host_wr_data on host_wr_valid & host_wr_ready.
REQ-025 SHALL compute host_rd_valid as (ep6_count > 0), present the EP6 head word combinationally on host_rd_data, and pop on host_rd_valid & host_rd_ready.
REQ-026 SHALL evaluate full and empty on the start-of-cycle count; a simultaneous push and pop on the same FIFO SHALL both occur and leave the count unchanged.
REQ-027 SHALL drop a bus write to a full EP6 even when a host drain occurs in the same cycle.
REQ-028 SHALL register usb_flaga = (ep2_count_next != 0) and usb_flagc = (ep6_count_next != depth), so both flags are valid in the cycle after the pointer update.
REQ-029 SHALL count a strobe held low for any number of cycles as one event; it SHALL NOT detect a 1->0 edge or level as an event.

Reset
REQ-030 SHALL, while reset = 1 at a rising edge, clear all pointers and counts, set usb_flaga = 0, usb_flagb = 0, usb_flagc = 1, ovf_err = 0, udf_err = 0, slrd_q = 1 and slwr_q = 1, and release usb_fd to high-Z.
REQ-031 SHALL discard FIFO contents on a reset asserted mid-transfer; a strobe rising in the first cycle after reset SHALL NOT generate an event unless the registered strobe was 0.

Verification
REQ-032 SHALL cover EP2 readout: host loads 16'hA5A5 then 16'h1234; the master reads with addr = 00, OE low and RD pulsed low for 9 cycles -> usb_fd = A5A5 before the first RD rise and 1234 after it; usb_flaga = 0 one cycle after the second rise.
REQ-033 SHALL cover EP6 write: master drives usb_fd = 16'hBEEF with addr = 10 and WR low for 9 cycles, then high -> ep6_count = 1, host_rd_data = BEEF, host_rd_valid = 1.
REQ-034 SHALL cover EP6 full: 16 writes, then a 17th of 16'hDEAD with host_rd_ready = 1 in the same cycle -> usb_flagc = 0 before the 17th write, ovf_err = 1 after it, and DEAD never appears on host_rd_data.
REQ-035 SHALL cover EP2 underflow: a read strobe with ep2_count = 0 -> udf_err = 1 and the pointers unchanged.
REQ-036 SHALL cover pointer wrap: 40 sequential host-load/bus-read words of incrementing data -> data returned in order across the wrap.
REQ-037 SHALL cover reset mid-transfer: reset asserted while WR is low with 5 words in EP6 -> counts = 0 and flags at their reset values, and no push when WR later rises.
